// File: rtl/vlan_inserter_if.sv
// AXI-Stream bundle used for the VLAN inserter ingress and egress ports.
interface vlan_inserter_if #(
   parameter int unsigned DATA_WIDTH = 256,
   parameter int unsigned USER_WIDTH = 128
);
   localparam int unsigned KEEP_WIDTH = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] tdata;
   logic [KEEP_WIDTH-1:0] tkeep;
   logic [USER_WIDTH-1:0] tuser;
   logic                  tvalid;
   logic                  tlast;
   logic                  tready;

   modport master (output tdata, tkeep, tuser, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tuser, tvalid, tlast, output tready);
endinterface

// File: rtl/vlan_inserter.sv
// Inserts an 802.1Q tag (81 00 + TCI) after the MAC addresses of frames from
// selected source ports, shifting the rest of the frame by four bytes.
module vlan_inserter #(
   parameter int unsigned C_M_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_S_AXIS_DATA_WIDTH  = 256,
   parameter int unsigned C_M_AXIS_TUSER_WIDTH = 128,
   parameter int unsigned C_S_AXIS_TUSER_WIDTH = 128,
   parameter logic [7:0]  TAG_PORT_MASK        = 8'h05
) (
   input  logic           axis_aclk,
   input  logic           axis_resetn,
   vlan_inserter_if.slave  s_axis,
   vlan_inserter_if.master m_axis,
   input  logic [11:0]    cfg_vid,
   input  logic [2:0]     cfg_pcp,
   input  logic           cfg_enable,
   output logic [31:0]    tagged_cnt,
   output logic [31:0]    passed_cnt
);
   localparam int unsigned S_DW = C_S_AXIS_DATA_WIDTH;
   localparam int unsigned S_KW = S_DW / 8;
   localparam int unsigned S_UW = C_S_AXIS_TUSER_WIDTH;
   localparam int unsigned M_DW = C_M_AXIS_DATA_WIDTH;
   localparam int unsigned M_KW = M_DW / 8;
   localparam int unsigned M_UW = C_M_AXIS_TUSER_WIDTH;

   typedef enum logic [1:0] {HEADER, TAG_BODY, PASS_BODY, EXTRA} state_t;

   state_t            state_q, state_d;
   logic [M_DW-1:0]   data_q, data_d;
   logic [M_KW-1:0]   keep_q, keep_d;
   logic [M_UW-1:0]   user_q, user_d;
   logic              valid_q, valid_d;
   logic              last_q, last_d;
   logic              tagged_q, tagged_d;
   logic [31:0]       carry_data_q, carry_data_d;
   logic [3:0]        carry_keep_q, carry_keep_d;

   logic [S_DW-1:0]   in_data;
   logic [S_KW-1:0]   in_keep;
   logic [S_UW-1:0]   in_user;
   logic              in_last;
   logic              load_ok_c;
   logic              ready_c;
   logic              in_fire_c;
   logic              tag_hit_c;
   logic              carry_need_c;

   assign in_data = s_axis.tdata;
   assign in_keep = s_axis.tkeep;
   assign in_user = s_axis.tuser;
   assign in_last = s_axis.tlast;

   // Output stage can take a new beat when empty or draining this cycle.
   assign load_ok_c    = ~valid_q | m_axis.tready;
   assign ready_c      = axis_resetn & load_ok_c & (state_q != EXTRA);
   assign in_fire_c    = s_axis.tvalid & ready_c;
   assign tag_hit_c    = cfg_enable & (|(in_user[23:16] & TAG_PORT_MASK)) &
                         (&in_keep[13:0]) & (in_data[111:96] != 16'h0081);
   assign carry_need_c = |in_keep[31:28];

   assign s_axis.tready = ready_c;
   assign m_axis.tdata  = data_q;
   assign m_axis.tkeep  = keep_q;
   assign m_axis.tuser  = user_q;
   assign m_axis.tvalid = valid_q;
   assign m_axis.tlast  = last_q;

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) state_q <= HEADER;
      else              state_q <= state_d;
   end

   // Next state and next contents of the output/carry registers.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid_q & ~m_axis.tready;
      data_d       = data_q;
      keep_d       = keep_q;
      user_d       = user_q;
      last_d       = last_q;
      tagged_d     = tagged_q;
      carry_data_d = carry_data_q;
      carry_keep_d = carry_keep_q;
      unique case (state_q)
         HEADER: begin
            if (in_fire_c) begin
               valid_d  = 1'b1;
               tagged_d = tag_hit_c;
               if (tag_hit_c) begin
                  data_d = {in_data[223:96], cfg_vid[7:0], cfg_pcp, 1'b0, cfg_vid[11:8],
                            8'h00, 8'h81, in_data[95:0]};
                  keep_d = {in_keep[27:12], 4'hF, in_keep[11:0]};
                  user_d = {in_user[S_UW-1:16], 16'(in_user[15:0] + 16'd4)};
                  carry_data_d = in_data[255:224];
                  carry_keep_d = in_keep[31:28];
                  last_d  = in_last & ~carry_need_c;
                  state_d = in_last ? (carry_need_c ? EXTRA : HEADER) : TAG_BODY;
               end else begin
                  data_d  = in_data;
                  keep_d  = in_keep;
                  user_d  = in_user;
                  last_d  = in_last;
                  state_d = in_last ? HEADER : PASS_BODY;
               end
            end
         end
         TAG_BODY: begin
            if (in_fire_c) begin
               valid_d      = 1'b1;
               data_d       = {in_data[223:0], carry_data_q};
               keep_d       = {in_keep[27:0], carry_keep_q};
               user_d       = in_user;
               carry_data_d = in_data[255:224];
               carry_keep_d = in_keep[31:28];
               last_d       = in_last & ~carry_need_c;
               if (in_last) state_d = carry_need_c ? EXTRA : HEADER;
            end
         end
         PASS_BODY: begin
            if (in_fire_c) begin
               valid_d = 1'b1;
               data_d  = in_data;
               keep_d  = in_keep;
               user_d  = in_user;
               last_d  = in_last;
               if (in_last) state_d = HEADER;
            end
         end
         EXTRA: begin
            if (load_ok_c) begin
               valid_d  = 1'b1;
               data_d   = {224'b0, carry_data_q};
               keep_d   = {28'b0, carry_keep_q};
               user_d   = '0;
               last_d   = 1'b1;
               tagged_d = 1'b1;
               state_d  = HEADER;
            end
         end
      endcase
   end

   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         valid_q      <= 1'b0;
         data_q       <= '0;
         keep_q       <= '0;
         user_q       <= '0;
         last_q       <= 1'b0;
         tagged_q     <= 1'b0;
         carry_data_q <= '0;
         carry_keep_q <= '0;
      end else begin
         valid_q      <= valid_d;
         data_q       <= data_d;
         keep_q       <= keep_d;
         user_q       <= user_d;
         last_q       <= last_d;
         tagged_q     <= tagged_d;
         carry_data_q <= carry_data_d;
         carry_keep_q <= carry_keep_d;
      end
   end

   // Frame counters advance when the final beat of a frame leaves.
   always_ff @(posedge axis_aclk or negedge axis_resetn) begin
      if (!axis_resetn) begin
         tagged_cnt <= '0;
         passed_cnt <= '0;
      end else if (valid_q && m_axis.tready && last_q) begin
         if (tagged_q) tagged_cnt <= tagged_cnt + 32'd1;
         else          passed_cnt <= passed_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_vlan_inserter.sv
// Bench for vlan_inserter: directed cases plus random traffic with backpressure,
// checked against a byte-level reference model.
module tb_vlan_inserter;
   typedef struct {
      logic [255:0] d;
      logic [31:0]  k;
      logic [127:0] u;
      logic         l;
      bit           first;
      int           fr;
   } beat_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [11:0] cfg_vid;
   logic [2:0]  cfg_pcp;
   logic        cfg_enable;
   logic [31:0] tagged_cnt;
   logic [31:0] passed_cnt;

   vlan_inserter_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) s_if ();
   vlan_inserter_if #(.DATA_WIDTH(256), .USER_WIDTH(128)) m_if ();

   vlan_inserter dut (
      .axis_aclk   (clk),
      .axis_resetn (rst_n),
      .s_axis      (s_if),
      .m_axis      (m_if),
      .cfg_vid     (cfg_vid),
      .cfg_pcp     (cfg_pcp),
      .cfg_enable  (cfg_enable),
      .tagged_cnt  (tagged_cnt),
      .passed_cnt  (passed_cnt)
   );

   always #5 clk = ~clk;

   byte unsigned  pool[$];
   int            f_off[$];
   int            f_len[$];
   logic [127:0]  f_user[$];
   beat_t         in_q[$];
   beat_t         exp_q[$];
   logic [255:0]  first_d[$];
   logic [127:0]  first_u;
   logic [31:0]   last_keep;
   int            n_vec, n_err, tag_tot, pass_tot, out_beats, sw_vid, vid_after;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Split a byte sequence into 32-byte beats, zero-filling unused lanes.
   task automatic chunk(input byte unsigned q[$], input logic [127:0] u, input int fr,
                        input bit to_exp);
      int nb = (q.size() + 31) / 32;
      for (int j = 0; j < nb; j++) begin
         beat_t b;
         b.d = '0;
         b.k = '0;
         for (int i = 0; i < 32; i++) begin
            if (32 * j + i < q.size()) begin
               b.d[8*i +: 8] = q[32*j+i];
               b.k[i]        = 1'b1;
            end
         end
         b.u = u;
         b.l = (j == nb - 1);
         b.first = (j == 0);
         b.fr = fr;
         if (to_exp) exp_q.push_back(b);
         else        in_q.push_back(b);
      end
   endtask

   task automatic add_frame(input int len, input logic [7:0] port, input bit pre_tag);
      byte unsigned q[$];
      int fr = f_len.size();
      logic [127:0] u = {$urandom(), $urandom(), $urandom(), 8'($urandom()), port, 16'(len)};
      f_off.push_back(pool.size());
      f_len.push_back(len);
      f_user.push_back(u);
      for (int i = 0; i < len; i++) begin
         byte unsigned b = 8'($urandom());
         if (pre_tag && i == 12) b = 8'h81;
         if (pre_tag && i == 13) b = 8'h00;
         q.push_back(b);
         pool.push_back(b);
      end
      chunk(q, u, fr, 1'b0);
   endtask

   // Reference: decide tagging from the first-beat view, insert 4 bytes at offset 12.
   task automatic expect_frame(input int fr);
      byte unsigned q[$];
      int len = f_len[fr];
      logic [127:0] u = f_user[fr];
      bit tag;
      for (int i = 0; i < len; i++) q.push_back(pool[f_off[fr] + i]);
      tag = cfg_enable && ((u[23:16] & 8'h05) != 8'h00) && (len >= 14) &&
            !(q[12] == 8'h81 && q[13] == 8'h00);
      if (tag) begin
         q.insert(12, cfg_vid[7:0]);
         q.insert(12, {cfg_pcp, 1'b0, cfg_vid[11:8]});
         q.insert(12, 8'h00);
         q.insert(12, 8'h81);
         u[15:0] = u[15:0] + 16'd4;
         tag_tot++;
      end else begin
         pass_tot++;
      end
      chunk(q, u, fr, 1'b1);
   endtask

   task automatic check_out();
      beat_t e;
      n_vec++;
      assert (exp_q.size() != 0) else begin
         n_err++;
         $error("FAIL unexpected_beat: observed %0h expected none", m_if.tdata);
      end
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("tdata", m_if.tdata, e.d);
         chk("tkeep", 256'(m_if.tkeep), 256'(e.k));
         chk("tlast", 256'(m_if.tlast), 256'(e.l));
         if (e.first) begin
            chk("tuser", 256'(m_if.tuser), 256'(e.u));
            first_d.push_back(m_if.tdata);
            first_u = m_if.tuser;
         end
         last_keep = m_if.tkeep;
         out_beats++;
      end
   endtask

   // One cycle: drive at the falling edge, then record the handshakes of the next rising edge.
   task automatic step(input int vpct, input int rpct, input bit rnd_cfg);
      beat_t b;
      @(negedge clk);
      if (sw_vid >= 0) begin
         cfg_vid = 12'(sw_vid);
         sw_vid  = -1;
      end
      if (rnd_cfg && $urandom_range(7) == 0) begin
         cfg_vid    = 12'($urandom());
         cfg_pcp    = 3'($urandom());
         cfg_enable = ($urandom_range(3) != 0);
      end
      if (in_q.size() > 0 && int'($urandom_range(99)) < vpct) begin
         s_if.tvalid = 1'b1;
         s_if.tdata  = in_q[0].d;
         s_if.tkeep  = in_q[0].k;
         s_if.tuser  = in_q[0].u;
         s_if.tlast  = in_q[0].l;
      end else begin
         s_if.tvalid = 1'b0;
      end
      m_if.tready = (int'($urandom_range(99)) < rpct);
      #1;
      if (m_if.tvalid && m_if.tready) check_out();
      if (s_if.tvalid && s_if.tready) begin
         b = in_q.pop_front();
         if (b.first) begin
            expect_frame(b.fr);
            if (vid_after >= 0) sw_vid = vid_after;
         end
      end
   endtask

   task automatic run(input int vpct, input int rpct, input bit rnd_cfg);
      int cyc = 0;
      while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 40000) begin
         step(vpct, rpct, rnd_cfg);
         cyc++;
      end
      n_vec++;
      assert (in_q.size() == 0 && exp_q.size() == 0) else begin
         n_err++;
         $error("FAIL timeout: observed %0d beats pending expected 0", in_q.size() + exp_q.size());
      end
      @(negedge clk);
      s_if.tvalid = 1'b0;
   endtask

   initial begin
      n_vec = 0; n_err = 0; tag_tot = 0; pass_tot = 0; out_beats = 0;
      sw_vid = -1; vid_after = -1;
      rst_n = 1'b1;
      s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tkeep = '0; s_if.tuser = '0; s_if.tlast = 1'b0;
      m_if.tready = 1'b0;
      cfg_vid = 12'h123; cfg_pcp = 3'd5; cfg_enable = 1'b1;
      #2 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_tvalid", 256'(m_if.tvalid), 256'(0));
      chk("rst_tlast",  256'(m_if.tlast), 256'(0));
      chk("rst_tdata",  m_if.tdata, 256'(0));
      chk("rst_tkeep",  256'(m_if.tkeep), 256'(0));
      chk("rst_tuser",  256'(m_if.tuser), 256'(0));
      chk("rst_tready", 256'(s_if.tready), 256'(0));
      chk("rst_tagged", 256'(tagged_cnt), 256'(0));
      chk("rst_passed", 256'(passed_cnt), 256'(0));
      rst_n = 1'b1;

      // 60-byte tagged frame
      first_d.delete(); out_beats = 0;
      add_frame(60, 8'h01, 1'b0);
      run(100, 100, 1'b0);
      chk("t60_tag_bytes", 256'(first_d[0][127:96]), 256'(32'h23A10081));
      chk("t60_len", 256'(first_u[15:0]), 256'(64));
      chk("t60_beats", 256'(out_beats), 256'(2));
      chk("t60_tagged_cnt", 256'(tagged_cnt), 256'(1));

      // single-beat boundaries: 28 bytes fits, 30 bytes spills into an extra beat
      out_beats = 0;
      add_frame(28, 8'h04, 1'b0);
      run(100, 100, 1'b0);
      chk("t28_beats", 256'(out_beats), 256'(1));
      out_beats = 0;
      add_frame(30, 8'h01, 1'b0);
      run(100, 100, 1'b0);
      chk("t30_beats", 256'(out_beats), 256'(2));
      chk("t30_extra_keep", 256'(last_keep), 256'(32'h3));
      chk("t30_tagged_cnt", 256'(tagged_cnt), 256'(3));

      // pass-through cases: pre-tagged, unselected port, disabled
      add_frame(60, 8'h01, 1'b1);
      add_frame(100, 8'h02, 1'b0);
      run(100, 100, 1'b0);
      cfg_enable = 1'b0;
      add_frame(80, 8'h01, 1'b0);
      run(100, 100, 1'b0);
      chk("pass_cnt", 256'(passed_cnt), 256'(3));
      chk("pass_tagged_cnt", 256'(tagged_cnt), 256'(3));

      // VID change right after a first beat is accepted
      cfg_enable = 1'b1; cfg_vid = 12'h001; first_d.delete(); vid_after = 2;
      add_frame(200, 8'h01, 1'b0);
      add_frame(64, 8'h04, 1'b0);
      run(100, 100, 1'b0);
      vid_after = -1; sw_vid = -1;
      chk("vid_first",  256'(first_d[0][127:112]), 256'(16'h01A0));
      chk("vid_second", 256'(first_d[1][127:112]), 256'(16'h02A0));

      // random traffic, gaps and backpressure, config churn
      for (int f = 0; f < 300; f++)
         add_frame(int'($urandom_range(1518, 14)), 8'(1 << $urandom_range(7)),
                   ($urandom_range(9) == 0));
      run(70, 50, 1'b1);
      chk("rnd_tagged_cnt", 256'(tagged_cnt), 256'(tag_tot));
      chk("rnd_passed_cnt", 256'(passed_cnt), 256'(pass_tot));

      // reset during the second beat of a 200-byte frame
      cfg_enable = 1'b1; cfg_vid = 12'h123; cfg_pcp = 3'd5;
      add_frame(200, 8'h01, 1'b0);
      step(100, 100, 1'b0);
      step(100, 100, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk("mid_rst_tvalid", 256'(m_if.tvalid), 256'(0));
      chk("mid_rst_tdata",  m_if.tdata, 256'(0));
      chk("mid_rst_tuser",  256'(m_if.tuser), 256'(0));
      chk("mid_rst_tkeep",  256'(m_if.tkeep), 256'(0));
      chk("mid_rst_tready", 256'(s_if.tready), 256'(0));
      chk("mid_rst_tagged", 256'(tagged_cnt), 256'(0));
      chk("mid_rst_passed", 256'(passed_cnt), 256'(0));
      in_q.delete(); exp_q.delete(); tag_tot = 0; pass_tot = 0;
      s_if.tvalid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      first_d.delete(); out_beats = 0;
      add_frame(64, 8'h01, 1'b0);
      run(100, 100, 1'b0);
      chk("post_rst_beats", 256'(out_beats), 256'(3));
      chk("post_rst_tag_bytes", 256'(first_d[0][127:96]), 256'(32'h23A10081));
      chk("post_rst_tagged", 256'(tagged_cnt), 256'(1));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
